// File: rtl/oisc8_ram_arbiter_if.sv
// Bus bundle between the OISC8 CPU memory unit, the secondary master and the RAM port.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface oisc8_ram_arbiter_if #(
  parameter int unsigned AWIDTH = 24,
  parameter int unsigned DWIDTH = 16
);
  // CPU side
  logic              cpu_rd_en;
  logic              cpu_wr_en;
  logic [AWIDTH-1:0] cpu_addr;
  logic [DWIDTH-1:0] cpu_wr_data;
  logic [DWIDTH-1:0] cpu_rd_data;
  logic              cpu_stall;
  // Secondary master (DMA / boot loader) side
  logic              dma_req;
  logic              dma_we;
  logic [AWIDTH-1:0] dma_addr;
  logic [DWIDTH-1:0] dma_wr_data;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DWIDTH-1:0] dma_rd_data;
  // RAM port
  logic              ram_rd_en;
  logic              ram_wr_en;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_wr_data;
  logic [DWIDTH-1:0] ram_rd_data;

  modport slave (
    input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data,
    output cpu_rd_data, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wr_data,
    output dma_gnt, dma_rvalid, dma_rd_data,
    output ram_rd_en, ram_wr_en, ram_addr, ram_wr_data,
    input  ram_rd_data
  );

  modport master (
    output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data,
    input  cpu_rd_data, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wr_data,
    input  dma_gnt, dma_rvalid, dma_rd_data,
    input  ram_rd_en, ram_wr_en, ram_addr, ram_wr_data,
    output ram_rd_data
  );
endinterface

// File: rtl/oisc8_ram_arbiter.sv
// RAM port arbiter: CPU has fixed priority, a starvation counter forces a one-cycle CPU
// stall so the secondary master always makes progress. Grants are zero-latency.
module oisc8_ram_arbiter #(
  parameter int unsigned AWIDTH       = 24,
  parameter int unsigned DWIDTH       = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                i_clk,
  input logic                i_rst,
  oisc8_ram_arbiter_if.slave io_bus
);

  // Counter must be at least one bit wide even when forcing is disabled.
  localparam int unsigned   CW       = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'((STARVE_LIMIT > 0) ? STARVE_LIMIT - 1 : 0);
  localparam logic          FORCE_EN = (STARVE_LIMIT != 0);

  logic [CW-1:0] r_wait_cnt;
  logic          r_stall;
  logic          r_rvalid;

  logic              w_cpu_req;
  logic              w_cpu_sel;
  logic              w_dma_sel;
  logic [AWIDTH-1:0] w_addr;
  logic [DWIDTH-1:0] w_wr_data;

  // Owner selection and RAM port steering.
  always_comb begin
    w_cpu_req = io_bus.cpu_rd_en | io_bus.cpu_wr_en;
    // During a forced stall the CPU is ignored; an absent DMA request leaves the port idle.
    w_cpu_sel = ~r_stall & w_cpu_req;
    w_dma_sel = io_bus.dma_req & (r_stall | ~w_cpu_req);
    w_addr    = w_dma_sel ? io_bus.dma_addr    : io_bus.cpu_addr;
    w_wr_data = w_dma_sel ? io_bus.dma_wr_data : io_bus.cpu_wr_data;

    io_bus.ram_rd_en   = w_cpu_sel ? io_bus.cpu_rd_en : (w_dma_sel & ~io_bus.dma_we);
    io_bus.ram_wr_en   = w_cpu_sel ? io_bus.cpu_wr_en : (w_dma_sel &  io_bus.dma_we);
    io_bus.ram_addr    = w_addr;
    io_bus.ram_wr_data = w_wr_data;

    io_bus.cpu_stall   = r_stall;
    io_bus.dma_gnt     = w_dma_sel;
    // Gated by reset so a read granted just before reset never reports valid data.
    io_bus.dma_rvalid  = r_rvalid & ~i_rst;
    io_bus.dma_rd_data = io_bus.ram_rd_data;
    io_bus.cpu_rd_data = io_bus.ram_rd_data;
  end

  // Starvation counter, one-cycle forced stall and DMA read-valid pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
      r_stall    <= 1'b0;
      r_rvalid   <= 1'b0;
    end else begin
      if (w_dma_sel || !io_bus.dma_req) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != LIMIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      r_stall  <= FORCE_EN & io_bus.dma_req & ~w_dma_sel & (r_wait_cnt == LIMIT_M1) & ~r_stall;
      r_rvalid <= w_dma_sel & ~io_bus.dma_we;
    end
  end

endmodule

// File: tb/tb_oisc8_ram_arbiter.sv
// Self-checking bench: five arbiters with different starvation limits, each with its own
// small RAM, checked every cycle against a behavioural model plus directed scenarios.
module tb_oisc8_ram_arbiter;

  localparam int N = 5;
  // Limits per instance: index 0 -> 8, 1 -> 4, 2 -> 2, 3 -> 1, 4 -> 0 (forcing disabled).
  localparam logic [N-1:0][7:0] LIMS = {8'd0, 8'd1, 8'd2, 8'd4, 8'd8};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-instance stimulus
  logic        cpu_rd [N];
  logic        cpu_wr [N];
  logic [23:0] cpu_addr [N];
  logic [15:0] cpu_wd [N];
  logic        dma_req [N];
  logic        dma_we [N];
  logic [23:0] dma_addr [N];
  logic [15:0] dma_wd [N];

  // Per-instance observed outputs
  logic        o_stall [N];
  logic        o_gnt [N];
  logic        o_rv [N];
  logic        o_rd [N];
  logic        o_wr [N];
  logic [23:0] o_addr [N];
  logic [15:0] o_wd [N];
  logic [15:0] o_drd [N];
  logic [15:0] o_crd [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    oisc8_ram_arbiter_if #(.AWIDTH(24), .DWIDTH(16)) bus ();
    logic [15:0] mem [256] = '{default: 16'h0000};
    logic [15:0] rd_q = 16'h0000;

    assign bus.cpu_rd_en   = cpu_rd[g];
    assign bus.cpu_wr_en   = cpu_wr[g];
    assign bus.cpu_addr    = cpu_addr[g];
    assign bus.cpu_wr_data = cpu_wd[g];
    assign bus.dma_req     = dma_req[g];
    assign bus.dma_we      = dma_we[g];
    assign bus.dma_addr    = dma_addr[g];
    assign bus.dma_wr_data = dma_wd[g];
    assign bus.ram_rd_data = rd_q;

    assign o_stall[g] = bus.cpu_stall;
    assign o_gnt[g]   = bus.dma_gnt;
    assign o_rv[g]    = bus.dma_rvalid;
    assign o_rd[g]    = bus.ram_rd_en;
    assign o_wr[g]    = bus.ram_wr_en;
    assign o_addr[g]  = bus.ram_addr;
    assign o_wd[g]    = bus.ram_wr_data;
    assign o_drd[g]   = bus.dma_rd_data;
    assign o_crd[g]   = bus.cpu_rd_data;

    oisc8_ram_arbiter #(
      .AWIDTH      (24),
      .DWIDTH      (16),
      .STARVE_LIMIT(int'(LIMS[g]))
    ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_bus(bus)
    );

    // RAM with one-cycle read latency; read returns the old word on a same-cycle write.
    always @(posedge clk) begin
      if (bus.ram_rd_en) rd_q <= mem[bus.ram_addr[7:0]];
      if (bus.ram_wr_en) mem[bus.ram_addr[7:0]] <= bus.ram_wr_data;
    end
  end

  // Reference model state
  int          m_run [N];     // consecutive denied request cycles
  bit          m_force [N];   // next cycle is a forced DMA slot
  bit          m_rv [N];      // read granted last cycle
  logic [15:0] m_rdata [N];
  logic [15:0] m_mem [N][256];

  // Expected outputs for the current cycle
  bit          e_stall [N];
  bit          e_gnt [N];
  bit          e_rd [N];
  bit          e_wr [N];
  logic [23:0] e_addr [N];
  logic [15:0] e_wd [N];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int g, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%h want=%h", tag, g, obs, exp);
    end
  endtask

  task automatic model_check();
    for (int g = 0; g < N; g++) begin
      bit creq;
      bit addr_known;
      creq = cpu_rd[g] | cpu_wr[g];
      e_stall[g] = m_force[g];
      e_gnt[g]   = m_force[g] ? dma_req[g] : (!creq && dma_req[g]);
      if (e_gnt[g]) begin
        e_rd[g] = !dma_we[g]; e_wr[g] = dma_we[g];
        e_addr[g] = dma_addr[g]; e_wd[g] = dma_wd[g];
      end else if (!m_force[g] && creq) begin
        e_rd[g] = cpu_rd[g]; e_wr[g] = cpu_wr[g];
        e_addr[g] = cpu_addr[g]; e_wd[g] = cpu_wd[g];
      end else begin
        e_rd[g] = 1'b0; e_wr[g] = 1'b0;
        e_addr[g] = cpu_addr[g]; e_wd[g] = cpu_wd[g];
      end
      // The wasted forced slot has no defined address.
      addr_known = !(m_force[g] && !dma_req[g]);
      chk("stall", g, o_stall[g], e_stall[g]);
      chk("gnt", g, o_gnt[g], e_gnt[g]);
      chk("rvalid", g, o_rv[g], m_rv[g] && !rst);
      chk("ram_rd_en", g, o_rd[g], e_rd[g]);
      chk("ram_wr_en", g, o_wr[g], e_wr[g]);
      if (addr_known) begin
        chk("ram_addr", g, o_addr[g], e_addr[g]);
        chk("ram_wr_data", g, o_wd[g], e_wd[g]);
      end
      chk("dma_rd_data", g, o_drd[g], m_rdata[g]);
      chk("cpu_rd_data", g, o_crd[g], m_rdata[g]);
    end
  endtask

  task automatic model_update();
    for (int g = 0; g < N; g++) begin
      bit denied;
      bit was_forced;
      if (e_rd[g]) m_rdata[g] = m_mem[g][e_addr[g][7:0]];
      if (e_wr[g]) m_mem[g][e_addr[g][7:0]] = e_wd[g];
      if (rst) begin
        m_run[g] = 0; m_force[g] = 0; m_rv[g] = 0;
      end else begin
        denied     = dma_req[g] && !e_gnt[g];
        was_forced = m_force[g];
        m_rv[g]    = e_gnt[g] && !dma_we[g];
        m_run[g]   = denied ? m_run[g] + 1 : 0;
        m_force[g] = (LIMS[g] != 0) && denied && !was_forced && (m_run[g] == int'(LIMS[g]));
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic set_all(input bit rd, input bit wr, input logic [23:0] ca,
                         input logic [15:0] cd, input bit req, input bit we,
                         input logic [23:0] da, input logic [15:0] dd);
    for (int g = 0; g < N; g++) begin
      cpu_rd[g] = rd; cpu_wr[g] = wr; cpu_addr[g] = ca; cpu_wd[g] = cd;
      dma_req[g] = req; dma_we[g] = we; dma_addr[g] = da; dma_wd[g] = dd;
    end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    set_all(0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Random protocol-respecting stimulus based on the model's view of the last cycle.
  task automatic gen_random();
    for (int g = 0; g < N; g++) begin
      int unsigned r;
      if (!e_stall[g]) begin
        r = $urandom_range(0, 7);
        cpu_rd[g]   = (r <= 3) || (r == 6);
        cpu_wr[g]   = (r == 4) || (r == 5) || (r == 6);
        cpu_addr[g] = 24'($urandom_range(0, 15));
        cpu_wd[g]   = 16'($urandom);
      end
      if (!(dma_req[g] && !e_gnt[g])) begin
        dma_req[g]  = ($urandom_range(0, 2) != 0);
        dma_we[g]   = $urandom_range(0, 1) == 1;
        dma_addr[g] = 24'($urandom_range(0, 15));
        dma_wd[g]   = 16'($urandom);
      end
    end
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      m_run[g] = 0; m_force[g] = 0; m_rv[g] = 0; m_rdata[g] = 16'h0;
      for (int a = 0; a < 256; a++) m_mem[g][a] = 16'h0;
    end

    // Reset held with CPU read and DMA request pending.
    rst = 1'b1;
    set_all(1, 0, 24'h000100, 16'h0, 1, 0, 24'h000200, 16'h0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("rst_stall", 0, o_stall[0], 1'b0);
      chk("rst_gnt", 0, o_gnt[0], 1'b0);
      chk("rst_rvalid", 0, o_rv[0], 1'b0);
      tick();
    end
    rst = 1'b0;
    settle();
    chk("post_rst_rd_en", 0, o_rd[0], 1'b1);
    tick();

    // DMA write then read with the CPU idle.
    reset_all();
    set_all(0, 0, 24'h0, 16'h0, 1, 1, 24'h000010, 16'hBEEF);
    settle();
    chk("dw_gnt", 0, o_gnt[0], 1'b1);
    chk("dw_wr_en", 0, o_wr[0], 1'b1);
    chk("dw_addr", 0, o_addr[0], 24'h000010);
    chk("dw_data", 0, o_wd[0], 16'hBEEF);
    tick();
    set_all(0, 0, 24'h0, 16'h0, 1, 0, 24'h000010, 16'h0);
    settle();
    chk("dr_gnt", 0, o_gnt[0], 1'b1);
    chk("dr_rd_en", 0, o_rd[0], 1'b1);
    tick();
    set_all(0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0);
    settle();
    chk("dr_rvalid", 0, o_rv[0], 1'b1);
    chk("dr_data", 0, o_drd[0], 16'hBEEF);
    tick();

    // CPU priority with limit 8.
    reset_all();
    set_all(1, 0, 24'h000020, 16'h0, 1, 0, 24'h000030, 16'h0);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("prio_gnt", 0, o_gnt[0], 1'b0);
      chk("prio_addr", 0, o_addr[0], 24'h000020);
      tick();
    end
    set_all(0, 0, 24'h000020, 16'h0, 1, 0, 24'h000030, 16'h0);
    settle();
    chk("prio_release_gnt", 0, o_gnt[0], 1'b1);
    chk("prio_release_addr", 0, o_addr[0], 24'h000030);
    tick();

    // Starvation with limit 4 (instance 1).
    reset_all();
    set_all(1, 0, 24'h000040, 16'h0, 1, 0, 24'h000044, 16'h0);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("starve_wait_stall", 1, o_stall[1], 1'b0);
      chk("starve_wait_gnt", 1, o_gnt[1], 1'b0);
      tick();
    end
    settle();
    chk("starve_force_stall", 1, o_stall[1], 1'b1);
    chk("starve_force_gnt", 1, o_gnt[1], 1'b1);
    chk("starve_force_addr", 1, o_addr[1], 24'h000044);
    tick();
    settle();
    chk("starve_after_stall", 1, o_stall[1], 1'b0);
    chk("starve_after_gnt", 1, o_gnt[1], 1'b0);
    chk("starve_after_rd_en", 1, o_rd[1], 1'b1);
    tick();

    // Withdrawal during the forced slot with limit 2 (instance 2).
    reset_all();
    set_all(1, 0, 24'h000050, 16'h0, 1, 0, 24'h000054, 16'h0);
    cyc();
    cyc();
    for (int g = 0; g < N; g++) dma_req[g] = 1'b0;
    settle();
    chk("wd_stall", 2, o_stall[2], 1'b1);
    chk("wd_rd_en", 2, o_rd[2], 1'b0);
    chk("wd_wr_en", 2, o_wr[2], 1'b0);
    chk("wd_gnt", 2, o_gnt[2], 1'b0);
    tick();
    settle();
    chk("wd_rvalid", 2, o_rv[2], 1'b0);
    chk("wd_stall_end", 2, o_stall[2], 1'b0);
    tick();

    // Reset right after a granted DMA read.
    reset_all();
    set_all(0, 0, 24'h0, 16'h0, 1, 0, 24'h000010, 16'h0);
    settle();
    chk("rr_gnt", 0, o_gnt[0], 1'b1);
    tick();
    rst = 1'b1;
    set_all(0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0);
    settle();
    chk("rr_rvalid_in_rst", 0, o_rv[0], 1'b0);
    tick();
    rst = 1'b0;
    settle();
    chk("rr_rvalid_after", 0, o_rv[0], 1'b0);
    tick();

    // Randomised traffic on all instances.
    reset_all();
    for (int c = 0; c < 800; c++) begin
      gen_random();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oisc8_ram_arbiter.md
Name: oisc8_ram_arbiter

Overview:
- Shares the single processor RAM port between the OISC8 CPU memory/stack unit and one secondary bus master (DMA / boot loader).
- The CPU has fixed priority.
- A starvation counter forces a one-cycle CPU stall, so the secondary master always makes forward progress.
- Sits between the CPU memory unit and the processor RAM port signals.

Parameters:
- AWIDTH, 24, RAM address width.
- DWIDTH, 16, RAM data width.
- STARVE_LIMIT, 8, consecutive un-granted DMA request cycles before a forced stall. 0 disables forcing (pure CPU priority).

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- cpu_rd_en  in  1  CPU read request
- cpu_wr_en  in  1  CPU write request
- cpu_addr  in  AWIDTH  CPU address
- cpu_wr_data  in  DWIDTH  CPU write data
- cpu_rd_data  out  DWIDTH  read data to CPU
- cpu_stall  out  1  freeze CPU pipeline/PC this cycle
- dma_req  in  1  secondary master request; held until granted
- dma_we  in  1  1 = write, 0 = read; qualified by dma_req
- dma_addr  in  AWIDTH  DMA address
- dma_wr_data  in  DWIDTH  DMA write data
- dma_gnt  out  1  DMA access issued this cycle
- dma_rvalid  out  1  dma_rd_data valid
- dma_rd_data  out  DWIDTH  read data to DMA
- ram_rd_en  out  1  RAM read enable
- ram_wr_en  out  1  RAM write enable
- ram_addr  out  AWIDTH  RAM address
- ram_wr_data  out  DWIDTH  RAM write data
- ram_rd_data  in  DWIDTH  RAM read data; valid one cycle after ram_rd_en

Behaviour:
- Clocking/reset: single clock clk. Reset rst is synchronous, active-high.
- State: wait_cnt (width $clog2(STARVE_LIMIT+1)), stall_q (1 bit), rvalid_q (1 bit).
- Reset: wait_cnt=0, stall_q=0, rvalid_q=0. Consequences:
  - cpu_stall=0, dma_gnt=0, dma_rvalid=0.
  - ram_rd_en/ram_wr_en follow the CPU inputs combinationally.
- Reset mid-operation: any pending dma_rvalid is dropped and never issued.
- Owner selection (combinational, per cycle):
  - FORCE (stall_q=1): cpu_stall=1 and CPU enables are ignored. If dma_req=1, the DMA owns the port and dma_gnt=1. If dma_req=0, the port is idle with both enables 0.
  - CPU (stall_q=0 and cpu_rd_en|cpu_wr_en): CPU signals pass through unchanged, including simultaneous rd+wr. dma_gnt=0.
  - DMA (stall_q=0, no CPU request, dma_req=1): dma_gnt=1.
    - ram_rd_en = ~dma_we, ram_wr_en = dma_we.
    - ram_addr = dma_addr, ram_wr_data = dma_wr_data.
  - IDLE: enables 0, ram_addr=cpu_addr, ram_wr_data=cpu_wr_data.
- Grant latency: zero cycles.
  - A DMA write completes in its dma_gnt cycle.
  - A DMA read returns one cycle later: dma_rvalid=rvalid_q, where rvalid_q <= dma_gnt & ~dma_we.
- Data paths: dma_rd_data = ram_rd_data and cpu_rd_data = ram_rd_data, unregistered. The CPU tracks its own read latency.
- DMA handshake:
  - dma_addr/dma_we/dma_wr_data stay stable while dma_req=1 and dma_gnt=0.
  - The master may deassert dma_req or present the next request in the cycle after dma_gnt.
  - Back-to-back grants are allowed.
- Starvation counter:
  - wait_cnt <= 0 if dma_gnt=1 or dma_req=0.
  - Otherwise wait_cnt <= wait_cnt+1, saturating at STARVE_LIMIT.
- Forced stall:
  - stall_q <= (STARVE_LIMIT!=0) & dma_req & ~dma_gnt & (wait_cnt==STARVE_LIMIT-1) & ~stall_q.
  - The stall is therefore exactly one cycle, entered the cycle after the LIMIT-th un-granted request cycle.
  - wait_cnt returns to 0 after FORCE.
- CPU stall contract: the CPU repeats its stalled request unchanged on the next cycle. The arbiter holds no CPU state.
- DMA withdrawal: if dma_req drops during FORCE, the cycle is wasted (no access) and the stall still occurs.
- STARVE_LIMIT=1: stall_q fires after every single denied cycle, giving alternating CPU/DMA slots under continuous contention.

Test Plan:
- Reset: rst=1 for 2 cycles with cpu_rd_en=1, dma_req=1 -> cpu_stall=0, dma_gnt=0, dma_rvalid=0. After release, ram_rd_en=1 (CPU owns the port).
- DMA idle access: no CPU request; DMA write addr 0x000010 data 0xBEEF -> same cycle dma_gnt=1, ram_wr_en=1, ram_addr=0x000010, ram_wr_data=0xBEEF. Then a DMA read of 0x000010 -> dma_rvalid=1 the next cycle with dma_rd_data=0xBEEF.
- CPU priority: cpu_rd_en and dma_req both high for 3 cycles, STARVE_LIMIT=8 -> dma_gnt=0 throughout, ram_addr=cpu_addr. CPU drops -> dma_gnt=1 that same cycle.
- Starvation: STARVE_LIMIT=4, CPU requests every cycle, dma_req held from cycle 0 -> cycles 0-3 CPU owns the port. Cycle 4: cpu_stall=1, dma_gnt=1, ram_addr=dma_addr. Cycle 5: CPU owns again and wait_cnt=0.
- Withdrawal: STARVE_LIMIT=2, dma_req dropped in the FORCE cycle -> cpu_stall=1, ram_rd_en=ram_wr_en=0, dma_rvalid=0 the next cycle.
- Reset mid-read: DMA read granted, rst=1 on the next cycle -> dma_rvalid=0.
